// File: rtl/mem_bridge_if.sv
// mem_bridge_if: bundle of the CPU-side strobes/status and the req/ack bus
// used by mem_bridge.
//   slave  modport : the bridge itself. It sees the CPU requests and the bus
//                    responses, and drives stall, instr/op/funct, mdr,
//                    bus_err and the bus request side.
//   master modport : the environment (CPU + memory) driving the bridge.
// Parameters: ADDR_W (address width), DATA_W (data width).
interface mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU side
  logic              cpu_rd;
  logic              cpu_wr;
  logic              cpu_ir;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [DATA_W-1:0] mdr;
  logic              bus_err;
  // Memory bus side
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_ir, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    output stall, instr, op, funct, mdr, bus_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_ir, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    input  stall, instr, op, funct, mdr, bus_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: memory-side stage of the multicycle CPU. Converts the CPU's
// level read/write strobes into one req/ack bus transfer with any number of
// wait states, holds the instruction register (op/funct decode slices) and
// the memory data register, and stalls the CPU until the transfer finishes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any transfer in flight
//   mb    : mem_bridge_if.slave (CPU strobes/status and bus req/ack)
// Parameters: ADDR_W, DATA_W, TIMEOUT (REQ cycles before bus error).
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to enable the bus timeout
// (ERR state, sticky bus_err). Without it REQ waits forever, bus_err = 0.
module mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       reset,
  mem_bridge_if.slave mb
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic              we_reg;
  logic              ir_reg;
  logic              cpu_req;
  logic              timeout_hit;

  assign cpu_req = mb.cpu_rd | mb.cpu_wr;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;

  // Cleared while IDLE, which is the only way into REQ, so every transfer
  // starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == REQ && !mb.bus_ack) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Counter would reach TIMEOUT at this edge: that is the last REQ cycle.
  assign timeout_hit = (state_reg == REQ) && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_hit    = 1'b0;
  assign timeout_unused = (TIMEOUT == 0);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; ack has priority over the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cpu_req) state_next = REQ;
      REQ: begin
        if (mb.bus_ack) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. bus_req is decoded from state so reset drops it at once.
  always_comb begin
    mb.stall   = 1'b0;
    mb.bus_req = 1'b0;
    mb.bus_err = 1'b0;
    case (state_reg)
      IDLE: mb.stall = cpu_req;
      REQ: begin
        mb.stall   = 1'b1;
        mb.bus_req = 1'b1;
      end
      ERR: begin
        mb.stall = 1'b1;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        mb.bus_err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Request latch and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      ir_reg    <= 1'b0;
      instr_reg <= '0;
      mdr_reg   <= '0;
    end else begin
      if (state_reg == IDLE && cpu_req) begin
        addr_reg  <= mb.cpu_addr;
        wdata_reg <= mb.cpu_wdata;
        we_reg    <= mb.cpu_wr;
        ir_reg    <= mb.cpu_ir & ~mb.cpu_wr;  // write wins over a simultaneous read
      end
      if (state_reg == REQ && mb.bus_ack && !we_reg) begin
        if (ir_reg) begin
          instr_reg <= mb.bus_rdata;
        end else begin
          mdr_reg <= mb.bus_rdata;
        end
      end
    end
  end

  assign mb.bus_we    = we_reg;
  assign mb.bus_addr  = addr_reg;
  assign mb.bus_wdata = wdata_reg;
  assign mb.instr     = instr_reg;
  assign mb.mdr       = mdr_reg;
  assign mb.op        = instr_reg[31:26];
  assign mb.funct     = instr_reg[5:0];

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: randomized scoreboard bench for mem_bridge. The stimulus
// process issues CPU transfers and pushes the expected outcome; a bus
// responder acks after the chosen number of wait cycles; a monitor checks
// bus signals during REQ and the outcome when stall drops.
module tb_mem_bridge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mb ();

  mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .mb   (mb)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_instr;
    logic [31:0] exp_mdr;
  } txn_t;

  txn_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model_instr = 32'h0;
  logic [31:0] model_mdr   = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One CPU transfer: hold the request until stall drops (DONE), then
  // release it just after the DONE edge.
  task automatic issue(input bit rd, input bit wr, input bit ir, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    txn_t t;
    int   n;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    t.waits = waits;
    if (!wr) begin
      if (ir) model_instr = rdata;
      else    model_mdr   = rdata;
    end
    t.exp_instr = model_instr;
    t.exp_mdr   = model_mdr;
    exp_q.push_back(t);
    $display("txn %s ir=%0b addr=%h wdata=%h rdata=%h waits=%0d",
             wr ? "WR" : "RD", ir, addr, wdata, rdata, waits);
    mb.cpu_rd = rd; mb.cpu_wr = wr; mb.cpu_ir = ir;
    mb.cpu_addr = addr; mb.cpu_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (mb.stall && n < 500);
    if (n >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL transfer_timeout: stall still %0b after %0d cycles, required 0", mb.stall, n);
      exp_q.delete();
    end
    @(posedge clk); #1;
    mb.cpu_rd = 1'b0; mb.cpu_wr = 1'b0;
    mb.cpu_ir = 1'($urandom); mb.cpu_addr = $urandom; mb.cpu_wdata = $urandom;
  endtask

  // Bus responder: ack on REQ cycle number 'waits'; random spurious acks
  // whenever no request is on the bus.
  initial begin
    int req_cycles;
    req_cycles = 0;
    mb.bus_ack = 1'b0;
    mb.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (mb.bus_req && exp_q.size() > 0) begin
        if (req_cycles == exp_q[0].waits) begin
          mb.bus_ack = 1'b1; mb.bus_rdata = exp_q[0].rdata;
        end else begin
          mb.bus_ack = 1'b0; mb.bus_rdata = $urandom;
        end
        req_cycles++;
      end else begin
        req_cycles = 0;
        mb.bus_ack = ($urandom_range(0, 3) == 0);
        mb.bus_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int   stall_cnt;
    txn_t t;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        stall_cnt = 0;
      end else if (mb.cpu_rd || mb.cpu_wr) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_request: queue empty, stall=%0b required none pending", mb.stall);
        end else if (mb.stall) begin
          stall_cnt++;
          if (mb.bus_req) begin
            check("bus_addr", mb.bus_addr, exp_q[0].addr);
            check("bus_we", 32'(mb.bus_we), 32'(exp_q[0].wr));
            check("bus_wdata", mb.bus_wdata, exp_q[0].wdata);
          end
        end else begin
          t = exp_q.pop_front();
          check("stall_cycles", stall_cnt, t.waits + 2);
          check("instr", mb.instr, t.exp_instr);
          check("op", 32'(mb.op), 32'(t.exp_instr[31:26]));
          check("funct", 32'(mb.funct), 32'(t.exp_instr[5:0]));
          check("mdr", mb.mdr, t.exp_mdr);
          check("done_bus_req", 32'(mb.bus_req), 32'd0);
          check("done_bus_err", 32'(mb.bus_err), 32'd0);
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    mb.cpu_rd = 1'b0; mb.cpu_wr = 1'b0; mb.cpu_ir = 1'b0;
    mb.cpu_addr = '0; mb.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_instr", mb.instr, 32'd0);
    check("rst_op", 32'(mb.op), 32'd0);
    check("rst_funct", 32'(mb.funct), 32'd0);
    check("rst_mdr", mb.mdr, 32'd0);
    check("rst_stall", 32'(mb.stall), 32'd0);
    check("rst_bus_req", 32'(mb.bus_req), 32'd0);
    check("rst_bus_err", 32'(mb.bus_err), 32'd0);
    check("rst_bus_addr", mb.bus_addr, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(1'b1, 1'b0, 1'b1, 32'h0,  32'h0,  32'h20080005, 2);
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0,  32'hDEADBEEF, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h40, 32'h55, $urandom,     1);

    for (int i = 0; i < 40; i++) begin
      bit wr, rd;
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      issue(rd, wr, 1'($urandom), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, $urandom,
            $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    mon_en = 1'b0;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    begin
      txn_t t;
      int   cnt;
      t.wr = 1'b0; t.addr = 32'h80; t.wdata = '0; t.rdata = '0; t.waits = 100000;
      t.exp_instr = model_instr; t.exp_mdr = model_mdr;
      exp_q.push_back(t);
      $display("txn RD timeout addr=%h (never acked)", t.addr);
      mb.cpu_rd = 1'b1; mb.cpu_ir = 1'b0; mb.cpu_addr = 32'h80;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (mb.bus_req) cnt++;
        else if (cnt > 0) break;
      end
      check("timeout_req_cycles", cnt, TIMEOUT);
      check("timeout_bus_err", 32'(mb.bus_err), 32'd1);
      check("timeout_bus_req", 32'(mb.bus_req), 32'd0);
      check("timeout_stall", 32'(mb.stall), 32'd1);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(mb.bus_err), 32'd1);
      check("err_stall_held", 32'(mb.stall), 32'd1);
      @(posedge clk); #2;
      reset = 1'b1; mb.cpu_rd = 1'b0; exp_q.delete();
      #1;
      check("err_reset_bus_err", 32'(mb.bus_err), 32'd0);
      @(negedge clk); reset = 1'b0;
      model_instr = 32'h0; model_mdr = 32'h0;
    end
`endif

    // Reset in the middle of a transfer.
    begin
      txn_t t;
      t.wr = 1'b0; t.addr = 32'hC0; t.wdata = '0; t.rdata = '0; t.waits = 100000;
      t.exp_instr = model_instr; t.exp_mdr = model_mdr;
      exp_q.push_back(t);
      $display("txn RD abort addr=%h (reset in REQ)", t.addr);
      @(posedge clk); #1;
      mb.cpu_rd = 1'b1; mb.cpu_ir = 1'b0; mb.cpu_addr = 32'hC0;
      repeat (3) @(posedge clk);
      #2;
      check("abort_pre_bus_req", 32'(mb.bus_req), 32'd1);
      reset = 1'b1;
      #1;
      check("abort_bus_req", 32'(mb.bus_req), 32'd0);
      check("abort_bus_err", 32'(mb.bus_err), 32'd0);
      check("abort_instr", mb.instr, 32'd0);
      check("abort_mdr", mb.mdr, 32'd0);
      mb.cpu_rd = 1'b0; exp_q.delete();
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("abort_idle_stall", 32'(mb.stall), 32'd0);
      model_instr = 32'h0; model_mdr = 32'h0;
    end

    @(posedge clk); #1;
    mon_en = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h8C820004, 1);
    issue(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h12345678, 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end
endmodule
